// File: rtl/buton_debounce.sv
// Pedestrian push-button conditioner: two-flop synchroniser, debounce FSM, single-cycle press pulse and cooldown.
// Optional `define BUTON_STATS_EN adds the saturating 8-bit pulse counter nr_apasari.
module buton_debounce #(
    parameter int WIDTH      = 6,
    parameter int DEB_CYCLES = 4,
    parameter int COOLDOWN   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             buton_raw,
    output logic             buton,
    output logic             buton_stabil,
    output logic             blocat,
`ifdef BUTON_STATS_EN
    output logic [7:0]       nr_apasari,
`endif
    output logic [1:0]       state_dbg,
    output logic [WIDTH-1:0] cnt_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONF_1 = 2'd1,
        APASAT = 2'd2,
        CONF_0 = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] DEB_LAST = WIDTH'(DEB_CYCLES - 1);
    localparam logic [WIDTH-1:0] CD_LOAD  = WIDTH'(COOLDOWN);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    logic             s1, s2;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cd_q, cd_d;
    logic             accept;
    logic             pulse_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2) begin
                    state_d = CONF_1;
                    cnt_d   = CNT_ONE;
                end
            end
            CONF_1: begin
                if (!s2) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = APASAT;
                    cnt_d   = CNT_ZERO;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            APASAT: begin
                if (!s2) begin
                    state_d = CONF_0;
                    cnt_d   = CNT_ONE;
                end
            end
            CONF_0: begin
                if (s2) begin
                    state_d = APASAT;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // A press accepted during cooldown is dropped here, never queued.
    always_comb begin
        pulse_d = accept && !blocat;
        cd_d    = cd_q;
        if (pulse_d) begin
            cd_d = CD_LOAD;
        end else if (cd_q != CNT_ZERO) begin
            cd_d = cd_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            cd_q         <= CNT_ZERO;
            buton        <= 1'b0;
            buton_stabil <= 1'b0;
            blocat       <= 1'b0;
        end else begin
            s1           <= buton_raw;
            s2           <= s1;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cd_q         <= cd_d;
            buton        <= pulse_d;
            buton_stabil <= (state_d == APASAT) || (state_d == CONF_0);
            blocat       <= (cd_d != CNT_ZERO);
        end
    end

`ifdef BUTON_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            nr_apasari <= 8'd0;
        end else if (pulse_d && (nr_apasari != 8'd255)) begin
            nr_apasari <= nr_apasari + 8'd1;
        end
    end
`endif

    assign state_dbg = state_q;
    assign cnt_dbg   = cnt_q;

endmodule

// File: tb/tb_buton_debounce.sv
// Bench for buton_debounce: table of press/glitch scenarios scored cycle by cycle, plus reset and glitch corner sequences.
module tb_buton_debounce;

    localparam int WIDTH      = 6;
    localparam int DEB_CYCLES = 4;
    localparam int COOLDOWN   = 16;
    localparam int W          = 35;

    typedef struct {
        int hi;
        int lo;
        bit exp_pulse;
        bit exp_acc;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             buton_raw;
    logic             buton;
    logic             buton_stabil;
    logic             blocat;
    logic [1:0]       state_dbg;
    logic [WIDTH-1:0] cnt_dbg;
`ifdef BUTON_STATS_EN
    logic [7:0]       nr_apasari;
    int               exp_pulses = 0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pulse = -1000;
    logic [W-1:0] exp_q[$];

    buton_debounce #(
        .WIDTH(WIDTH),
        .DEB_CYCLES(DEB_CYCLES),
        .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .buton_raw(buton_raw),
        .buton(buton),
        .buton_stabil(buton_stabil),
        .blocat(blocat),
`ifdef BUTON_STATS_EN
        .nr_apasari(nr_apasari),
`endif
        .state_dbg(state_dbg),
        .cnt_dbg(cnt_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // scoreboard: entries are {edge, buton, buton_stabil, blocat}
    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0][34:3]) <= cyc) begin
            logic [W-1:0] item;
            item = exp_q.pop_front();
            check_val("sb_edge", int'(item[34:3]), cyc);
            check_val("sb_buton", int'(buton), int'(item[2]));
            check_val("sb_stabil", int'(buton_stabil), int'(item[1]));
            check_val("sb_blocat", int'(blocat), int'(item[0]));
        end
    end

    // driver: called just after a posedge; raw driven at step t is first sampled at edge N+t
    task automatic run_press(input int hi, input int lo, input bit exp_pulse, input bit exp_acc);
        for (int t = 0; t < hi + lo; t++) begin
            int  e;
            int  d;
            bit  b;
            bit  s;
            bit  bl;
            buton_raw = (t < hi);
            e = cyc + 1;
            b = exp_pulse && (t == DEB_CYCLES + 1);
            s = exp_acc && (t >= DEB_CYCLES + 1) && (t < hi + DEB_CYCLES + 1);
            if (b) begin
                last_pulse = e;
`ifdef BUTON_STATS_EN
                if (exp_pulses < 255) exp_pulses++;
`endif
            end
            d  = e - last_pulse;
            bl = (COOLDOWN > 0) && (d >= 0) && (d <= COOLDOWN - 1);
            exp_q.push_back({32'(e), b, s, bl});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        buton_raw = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[12];

    initial begin
        int pulses;
        int falls;
        logic prev_stabil;

        // hi, lo, pulse expected, press accepted
        vecs[0]  = '{10, 20, 1'b1, 1'b1};  // clean press
        vecs[1]  = '{3,  1,  1'b0, 1'b0};  // bounce 1,1,1,0
        vecs[2]  = '{3,  1,  1'b0, 1'b0};  // bounce 1,1,1,0
        vecs[3]  = '{6,  20, 1'b1, 1'b1};  // then a solid hold
        vecs[4]  = '{2,  3,  1'b0, 1'b0};  // short glitch
        vecs[5]  = '{4,  6,  1'b1, 1'b1};  // cooldown: first press
        vecs[6]  = '{4,  16, 1'b0, 1'b1};  // 10 cycles later: dropped
        vecs[7]  = '{4,  20, 1'b1, 1'b1};  // 30 cycles after first
        vecs[8]  = '{4,  12, 1'b1, 1'b1};  // boundary pair: pulses 16 apart
        vecs[9]  = '{4,  13, 1'b0, 1'b1};  // 16 after: still blocked
        vecs[10] = '{4,  13, 1'b1, 1'b1};
        vecs[11] = '{4,  13, 1'b1, 1'b1};  // 17 after: accepted

        // reset held 3 cycles with the button pressed
        rst = 1'b1;
        buton_raw = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_val("rst_buton", int'(buton), 0);
            check_val("rst_stabil", int'(buton_stabil), 0);
            check_val("rst_blocat", int'(blocat), 0);
            check_val("rst_state", int'(state_dbg), 0);
            check_val("rst_cnt", int'(cnt_dbg), 0);
`ifdef BUTON_STATS_EN
            check_val("rst_nr", int'(nr_apasari), 0);
`endif
        end
        rst = 1'b0;
        last_pulse = -1000;
        run_press(8, 20, 1'b1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_press(vecs[i].hi, vecs[i].lo, vecs[i].exp_pulse, vecs[i].exp_acc);
        end
        idle_cycles(3);
        check_val("sb_drained", exp_q.size(), 0);

        // release glitch of 3 cycles during a hold: one pulse, one stabil fall
        idle_cycles(20);
        pulses = 0;
        falls = 0;
        prev_stabil = buton_stabil;
        for (int t = 0; t < 40; t++) begin
            buton_raw = (t < 10) || (t >= 13 && t < 23);
            @(posedge clk);
            #1;
            if (buton) pulses++;
            if (prev_stabil && !buton_stabil) falls++;
            prev_stabil = buton_stabil;
        end
        check_val("glitch_pulses", pulses, 1);
        check_val("glitch_falls", falls, 1);
        check_val("glitch_stabil_end", int'(buton_stabil), 0);

        // reset while in CONF_1
        idle_cycles(20);
        buton_raw = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val("mid_state_conf1", int'(state_dbg), 1);
        rst = 1'b1;
        buton_raw = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_state_idle", int'(state_dbg), 0);
        check_val("mid_cnt", int'(cnt_dbg), 0);
        rst = 1'b0;
        pulses = 0;
        for (int t = 0; t < 15; t++) begin
            @(posedge clk);
            #1;
            if (buton || buton_stabil) pulses++;
        end
        check_val("mid_no_pulse", pulses, 0);
        last_pulse = -1000;

`ifdef BUTON_STATS_EN
        check_val("nr_after_rst", int'(nr_apasari), 0);
        exp_pulses = 0;
        for (int i = 0; i < 3; i++) run_press(4, 13, 1'b1, 1'b1);
        idle_cycles(2);
        check_val("nr_three", int'(nr_apasari), 3);
        run_press(4, 6, 1'b1, 1'b1);
        run_press(4, 10, 1'b0, 1'b1);
        idle_cycles(2);
        check_val("nr_dropped", int'(nr_apasari), 4);
        for (int i = 0; i < 300; i++) run_press(4, 13, 1'b1, 1'b1);
        idle_cycles(2);
        check_val("nr_model", int'(nr_apasari), exp_pulses);
        check_val("nr_saturated", int'(nr_apasari), 255);
`endif

        idle_cycles(3);
        check_val("sb_final_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
